// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/status bundle between the instruction pipeline and
// the program-counter sequencer.
//   enable    - advance the sequencer (low = stall)
//   is_branch - conditional jump in EXECUTE
//   jump      - branch-taken decision from the compare stage
//   is_call   - unconditional call
//   is_ret    - return
//   target    - absolute branch/call destination
//   pc        - address of the instruction being fetched/executed
//   fetch     - instruction memory read strobe (high in FETCH)
//   taken     - one-cycle pulse after a redirect
//   stack_err - sticky return-stack overflow/underflow flag
interface pc_sequencer_if;
  localparam int unsigned PC_W = 16;

  logic            enable;
  logic            is_branch;
  logic            jump;
  logic            is_call;
  logic            is_ret;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc;
  logic            fetch;
  logic            taken;
  logic            stack_err;

  // Pipeline side drives control, reads status.
  modport master (
    output enable, is_branch, jump, is_call, is_ret, target,
    input  pc, fetch, taken, stack_err
  );

  // Sequencer side.
  modport slave (
    input  enable, is_branch, jump, is_call, is_ret, target,
    output pc, fetch, taken, stack_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: two-state (FETCH/EXECUTE) program-counter sequencer with
// conditional branch, call and return support.
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset (highest priority)
//   bus   - pc_sequencer_if.slave: control inputs and pc/fetch/taken/stack_err
// Parameters: RESET_PC (pc after reset), STACK_DEPTH (return-stack entries,
// power of two, 2..16).
// Optional feature macro RET_STACK_EN: when defined, calls push a return
// address and returns pop it, with a sticky overflow/underflow flag. When
// undefined there is no stack: a call is a plain jump, a return is a normal
// pc+1 step and stack_err is tied low.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned STACK_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam int unsigned PC_W = 16;

  // Elaboration-time guard on the stack geometry.
  if (STACK_DEPTH < 2 || STACK_DEPTH > 16 ||
      (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_sequencer: STACK_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic [PC_W-1:0] pc_inc;

`ifdef RET_STACK_EN
  // sp counts valid entries, so it needs one bit more than the index.
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  logic [PC_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic            err_q, err_d;
  logic            do_push;
  logic [IDX_W-1:0] top_idx;

  assign top_idx = IDX_W'(sp_q - SP_W'(1));
`endif

  // Return address and fall-through both wrap naturally at 16 bits.
  assign pc_inc = pc_q + 16'd1;

  // Next-state and redirect selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
`ifdef RET_STACK_EN
    sp_d    = sp_q;
    err_d   = err_q;
    do_push = 1'b0;
`endif
    if (bus.enable) begin
      case (state_q)
        ST_FETCH: state_d = ST_EXEC;
        ST_EXEC: begin
          state_d = ST_FETCH;
`ifdef RET_STACK_EN
          if (bus.is_ret) begin
            if (sp_q != '0) begin
              pc_d    = stack_q[top_idx];
              sp_d    = sp_q - SP_W'(1);
              taken_d = 1'b1;
            end else begin
              // Underflow: not a redirect, just fall through.
              pc_d  = pc_inc;
              err_d = 1'b1;
            end
          end else if (bus.is_call) begin
            if (sp_q != SP_W'(STACK_DEPTH)) begin
              do_push = 1'b1;
              sp_d    = sp_q + SP_W'(1);
            end else begin
              // Overflow: the jump still happens, the return address is lost.
              err_d = 1'b1;
            end
            pc_d    = bus.target;
            taken_d = 1'b1;
          end else if (bus.is_branch && bus.jump) begin
            pc_d    = bus.target;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
`else
          if (bus.is_ret) begin
            pc_d = pc_inc;
          end else if (bus.is_call || (bus.is_branch && bus.jump)) begin
            pc_d    = bus.target;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
`endif
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
`ifdef RET_STACK_EN
      sp_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
`ifdef RET_STACK_EN
      sp_q    <= sp_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef RET_STACK_EN
  // Stack storage; emptiness is tracked by sp_q alone, so no reset needed.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      stack_q[IDX_W'(sp_q)] <= pc_inc;
    end
  end

  assign bus.stack_err = err_q;
`else
  assign bus.stack_err = 1'b0;
`endif

  assign bus.pc    = pc_q;
  assign bus.fetch = (state_q == ST_FETCH);
  assign bus.taken = taken_q;
endmodule
